sram_sample_store: RTL
======================

// Module: sram_sample_store
// PURPOSE
//  Parametrised capture memory behind the sampler: byte lanes with 1/2/4 samples packed per word.
//  Circular capture with overwrite-oldest and a saturating fill count.
//  Stream readout with full valid/ready backpressure, oldest-first or newest-first, tlast on final sample.
//  Sits between data_align and the SUMP/UART transmitter; replaces the fixed 4-lane store.
// PARAMETERS
//  LANES  4       byte lanes per RAM word (power of two, >=2)
//  LW     8       bits per lane
//  MSZ    6144    RAM depth in words
//  MAW    13      word address width (2**MAW >= MSZ)
//  SAW    MAW+2   sample index width (2**SAW >= MSZ*LANES)
//  MDW    LANES*LW  data width
// PORTS
//  clk         in   1      system clock
//  rst         in   1      asynchronous reset, active low
//  cfg_load    in   1      latch cfg_*, clear pointers/fill, enter CAPTURE
//  cfg_mask    in   LANES  enabled lane groups (bit=1 enabled); k = popcount
//  cfg_rev     in   1      1 = read newest-first (SUMP order), 0 = oldest-first
//  mwr_tready  out  1      write accept
//  mwr_tvalid  in   1      write beat valid
//  mwr_tlast   in   1      final capture beat
//  mwr_tdata   in   MDW    sample, right-aligned (low S lanes used)
//  mrd_start   in   1      begin readout (DONE only)
//  mrd_tready  in   1      downstream ready
//  mrd_tvalid  out  1      read beat valid
//  mrd_tlast   out  1      last sample of readout
//  mrd_tkeep   out  LANES  valid lanes, low S bits set
//  mrd_tdata   out  MDW    sample, right-aligned, upper lanes zero
//  fill        out  SAW    stored sample count
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; all pointers/fill 0; every output 0.
//  Packing at cfg_load: P = largest power of two with P*k <= LANES (k=0 treated as LANES).
//   S = LANES/P lanes per sample. CAP = MSZ*P samples. Config is frozen until the next cfg_load.
//  Sample index n: word = n/P, slot = n%P; sample occupies lanes [slot*S +: S] of that word.
//   Write is a byte-enabled write of those lanes only.
//  States: IDLE -cfg_load-> CAPTURE -accepted tlast-> DONE -mrd_start-> READOUT -last handshake-> DONE.
//  cfg_load in any state -> CAPTURE next cycle, fill=0, wr_idx=0, mrd_tvalid=0 (abort, no tlast).
//  mwr_tready = (state==CAPTURE) & ~cfg_load (combinational). Beat accepted when tvalid&tready.
//   Each accepted beat, tlast included, is written at wr_idx.
//   wr_idx wraps CAP-1 -> 0. fill += 1, saturating at CAP.
//  Beats outside CAPTURE are not accepted and not stored.
//  READOUT covers fill samples. First index is (wr_idx-fill) mod CAP if cfg_rev=0, else (wr_idx-1) mod CAP.
//   Index steps +1 / -1 mod CAP.
//  RAM read latency is 1 cycle; an output register plus a 1-entry skid gives full throughput.
//   First mrd_tvalid appears 2 cycles after mrd_start. One beat per cycle while mrd_tready=1.
//  While mrd_tvalid & ~mrd_tready: tdata/tkeep/tlast held stable, no sample skipped or repeated.
//  mrd_tlast=1 only with the fill-th sample. After its handshake, mrd_tvalid=0 and state DONE.
//   A new mrd_start replays the identical sequence.
//  mrd_start with fill=0: no beats, stays DONE. mrd_start outside DONE: ignored.
//  fill and the RAM contents survive DONE/READOUT. Only cfg_load or rst clears fill.
// TESTING
//  T1 cfg_mask=1111, cfg_rev=1, write 0x11223344,0x55667788(tlast), start, tready=1
//     -> tdata 0x55667788,0x11223344; tkeep=1111; tlast on 2nd; fill=2.
//  T2 cfg_mask=0001 (P=4), cfg_rev=0, write bytes 0x01..0x06 (tlast on 0x06)
//     -> reads 0x01..0x06, tkeep=0001, upper bytes 0, fill=6.
//  T3 cfg_mask=0110 (P=2), MSZ=4, write 10 samples 0..9
//     -> fill=8; oldest-first reads 2..9; newest-first reads 9..2.
//  T4 backpressure: T1 data, toggle mrd_tready 1,0,0,1 random
//     -> every beat delivered once, data stable while stalled.
//  T5 cfg_load mid-READOUT -> mrd_tvalid=0 next cycle, fill=0, mwr_tready=1 in following cycle.
//  T6 rst=0 asserted mid-CAPTURE off-edge -> outputs 0 immediately; after release, state IDLE and mwr_tready=0.

Source files
------------

// File: rtl/sram_sample_store_if.sv
// Capture-store bus: config, write stream, read stream and fill count.
// slave = store side, master = sampler/transmitter side.
interface sram_sample_store_if #(
  parameter int LANES = 4,
  parameter int LW    = 8,
  parameter int SAW   = 15,
  parameter int MDW   = LANES * LW
);
  logic             cfg_load;
  logic [LANES-1:0] cfg_mask;
  logic             cfg_rev;
  logic             mwr_tready;
  logic             mwr_tvalid;
  logic             mwr_tlast;
  logic [MDW-1:0]   mwr_tdata;
  logic             mrd_start;
  logic             mrd_tready;
  logic             mrd_tvalid;
  logic             mrd_tlast;
  logic [LANES-1:0] mrd_tkeep;
  logic [MDW-1:0]   mrd_tdata;
  logic [SAW-1:0]   fill;

  modport slave (
    input  cfg_load, cfg_mask, cfg_rev,
    input  mwr_tvalid, mwr_tlast, mwr_tdata,
    input  mrd_start, mrd_tready,
    output mwr_tready,
    output mrd_tvalid, mrd_tlast,
    output mrd_tkeep, mrd_tdata,
    output fill
  );

  modport master (
    output cfg_load, cfg_mask, cfg_rev,
    output mwr_tvalid, mwr_tlast, mwr_tdata,
    output mrd_start, mrd_tready,
    input  mwr_tready,
    input  mrd_tvalid, mrd_tlast,
    input  mrd_tkeep, mrd_tdata,
    input  fill
  );
endinterface

// File: rtl/sram_sample_store.sv
// Circular packed-sample capture RAM with backpressured stream readout.
// Ports: clk, rst (async, active low), bus (cfg_*, mwr_*, mrd_*, fill).
module sram_sample_store #(
  parameter int LANES = 4,
  parameter int LW    = 8,
  parameter int MSZ   = 6144,
  parameter int MAW   = 13,
  parameter int SAW   = MAW + 2,
  parameter int MDW   = LANES * LW
) (
  input  logic clk,
  input  logic rst,
  sram_sample_store_if.slave bus
);
  localparam int SLW = $clog2(LANES);
  localparam int PLW = SLW + 1;
  localparam int CW  = SAW + 1;
  localparam logic [SAW-1:0] ONE_S = 1;
  localparam logic [CW-1:0]  ONE_C = 1;

  typedef enum logic [1:0] {
    IDLE, CAPTURE, DONE, READOUT
  } state_e;

  state_e state_q, state_d;

  logic [PLW-1:0] plog_q, plog_d;
  logic [CW-1:0]  cap_q, cap_d;
  logic           rev_q, rev_d;
  logic [SAW-1:0] wr_idx_q, wr_idx_d;
  logic [SAW-1:0] fill_q, fill_d;
  logic [SAW-1:0] rd_idx_q, rd_idx_d;
  logic [SAW-1:0] rd_left_q, rd_left_d;
  logic           infl_q, infl_d;
  logic           rlast_q, rlast_d;
  logic [SLW-1:0] rslot_q, rslot_d;
  logic           ov_q, ov_d;
  logic           ol_q, ol_d;
  logic [MDW-1:0] od_q, od_d;
  logic           sv_q, sv_d;
  logic           sl_q, sl_d;
  logic [MDW-1:0] sd_q, sd_d;

  logic [MDW-1:0] mem [MSZ];
  logic [MDW-1:0] ram_q;

  logic cfg_load;
  logic wr_rdy;
  logic wr_acc;
  logic pop;
  logic start;
  logic issue;

  assign cfg_load = bus.cfg_load;
  assign wr_acc   = bus.mwr_tvalid & wr_rdy;
  assign pop      = ov_q & bus.mrd_tready;
  assign start    = (state_q == DONE) & bus.mrd_start
                  & ~cfg_load & (fill_q != '0);

  // Packing: P = 2**plog samples per word.
  int k;
  always_comb begin
    plog_d = plog_q;
    cap_d  = cap_q;
    rev_d  = rev_q;
    k      = 0;
    if (cfg_load) begin
      for (int i = 0; i < LANES; i++)
        k += int'(bus.cfg_mask[i]);
      if (k == 0) k = LANES;
      plog_d = '0;
      for (int i = 0; i <= SLW; i++)
        if ((k << i) <= LANES) plog_d = PLW'(i);
      cap_d = CW'(MSZ) << plog_d;
      rev_d = bus.cfg_rev;
    end
  end

  logic [PLW-1:0]   s_lanes;
  logic [SAW-1:0]   pmask;
  logic [LANES-1:0] keep_s;
  logic [MDW-1:0]   dmask;

  assign s_lanes = PLW'(LANES >> plog_q);
  assign pmask   = SAW'((32'd1 << plog_q) - 32'd1);

  always_comb begin
    keep_s = '0;
    dmask  = '0;
    for (int l = 0; l < LANES; l++) begin
      keep_s[l] = (l < int'(s_lanes));
      dmask[l*LW +: LW] = {LW{keep_s[l]}};
    end
  end

  logic [MAW-1:0]   waddr;
  logic [SLW-1:0]   wslot;
  logic [LANES-1:0] wbe;
  logic [MDW-1:0]   wdata;
  int               wsh;

  always_comb begin
    waddr = MAW'(wr_idx_q >> plog_q);
    wslot = SLW'(wr_idx_q & pmask);
    wsh   = int'(wslot) * int'(s_lanes);
    wbe   = keep_s << wsh;
    wdata = (bus.mwr_tdata & dmask) << (wsh * LW);
  end

  always_comb begin
    wr_idx_d = wr_idx_q;
    fill_d   = fill_q;
    if (cfg_load) begin
      wr_idx_d = '0;
      fill_d   = '0;
    end else if (wr_acc) begin
      wr_idx_d = (CW'(wr_idx_q) + ONE_C == cap_q)
               ? '0 : wr_idx_q + ONE_S;
      if (CW'(fill_q) != cap_q)
        fill_d = fill_q + ONE_S;
    end
  end

  logic [SAW-1:0] first_idx;
  logic [SAW-1:0] cur_idx;
  logic [SAW-1:0] cur_left;
  logic [SAW-1:0] nxt_idx;
  logic [MAW-1:0] raddr;

  always_comb begin
    if (rev_q)
      first_idx = (wr_idx_q == '0)
                ? SAW'(cap_q - ONE_C) : wr_idx_q - ONE_S;
    else if (wr_idx_q >= fill_q)
      first_idx = wr_idx_q - fill_q;
    else
      first_idx = SAW'(CW'(wr_idx_q) + cap_q - CW'(fill_q));
    cur_idx  = start ? first_idx : rd_idx_q;
    cur_left = start ? fill_q : rd_left_q;
    if (rev_q)
      nxt_idx = (cur_idx == '0)
              ? SAW'(cap_q - ONE_C) : cur_idx - ONE_S;
    else
      nxt_idx = (CW'(cur_idx) + ONE_C == cap_q)
              ? '0 : cur_idx + ONE_S;
    raddr = MAW'(cur_idx >> plog_q);
  end

  // Only issue a read if the out reg + skid can absorb it
  // even when the consumer stalls from now on.
  int occ;
  always_comb begin
    occ = int'(ov_q) + int'(sv_q) + int'(infl_q) - int'(pop);
    issue = (start | (state_q == READOUT)) & ~cfg_load
          & (cur_left != '0) & (occ <= 1);
  end

  always_comb begin
    rd_idx_d  = rd_idx_q;
    rd_left_d = rd_left_q;
    rslot_d   = rslot_q;
    rlast_d   = rlast_q;
    infl_d    = issue;
    if (issue) begin
      rd_idx_d  = nxt_idx;
      rd_left_d = cur_left - ONE_S;
      rslot_d   = SLW'(cur_idx & pmask);
      rlast_d   = (cur_left == ONE_S);
    end
    if (cfg_load) rd_left_d = '0;
  end

  logic [MDW-1:0] in_data;
  int             rsh;

  always_comb begin
    rsh     = int'(rslot_q) * int'(s_lanes) * LW;
    in_data = (ram_q >> rsh) & dmask;
    ov_d = ov_q;
    ol_d = ol_q;
    od_d = od_q;
    sv_d = sv_q;
    sl_d = sl_q;
    sd_d = sd_q;
    if (pop) begin
      ov_d = sv_q;
      ol_d = sl_q;
      od_d = sd_q;
      sv_d = 1'b0;
    end
    if (infl_q) begin
      if (!ov_d) begin
        ov_d = 1'b1;
        ol_d = rlast_q;
        od_d = in_data;
      end else begin
        sv_d = 1'b1;
        sl_d = rlast_q;
        sd_d = in_data;
      end
    end
    if (cfg_load) begin
      ov_d = 1'b0;
      sv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = IDLE;
      CAPTURE: if (wr_acc & bus.mwr_tlast) state_d = DONE;
      DONE:    if (start) state_d = READOUT;
      READOUT: if (pop & ol_q) state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (cfg_load) state_d = CAPTURE;
  end

  always_comb begin
    wr_rdy         = (state_q == CAPTURE) & ~cfg_load;
    bus.mwr_tready = wr_rdy;
    bus.mrd_tvalid = ov_q;
    bus.mrd_tlast  = ov_q & ol_q;
    bus.mrd_tkeep  = ov_q ? keep_s : '0;
    bus.mrd_tdata  = ov_q ? od_q : '0;
    bus.fill       = fill_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      plog_q    <= '0;
      cap_q     <= '0;
      rev_q     <= 1'b0;
      wr_idx_q  <= '0;
      fill_q    <= '0;
      rd_idx_q  <= '0;
      rd_left_q <= '0;
      infl_q    <= 1'b0;
      rlast_q   <= 1'b0;
      rslot_q   <= '0;
      ov_q      <= 1'b0;
      ol_q      <= 1'b0;
      od_q      <= '0;
      sv_q      <= 1'b0;
      sl_q      <= 1'b0;
      sd_q      <= '0;
    end else begin
      plog_q    <= plog_d;
      cap_q     <= cap_d;
      rev_q     <= rev_d;
      wr_idx_q  <= wr_idx_d;
      fill_q    <= fill_d;
      rd_idx_q  <= rd_idx_d;
      rd_left_q <= rd_left_d;
      infl_q    <= infl_d;
      rlast_q   <= rlast_d;
      rslot_q   <= rslot_d;
      ov_q      <= ov_d;
      ol_q      <= ol_d;
      od_q      <= od_d;
      sv_q      <= sv_d;
      sl_q      <= sl_d;
      sd_q      <= sd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      for (int l = 0; l < LANES; l++)
        if (wbe[l]) mem[waddr][l*LW +: LW] <= wdata[l*LW +: LW];
    if (issue) ram_q <= mem[raddr];
  end
endmodule
